// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port synchronous data memory.
// Define MEM_ARB_LOCK_EN to let a requester hold the bus across locked transfers.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic          m0_lock,
  input  logic          m1_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  logic last, rd_pend, rd_owner;
  logic elig0, elig1, win;
`ifdef MEM_ARB_LOCK_EN
  logic lock_act, lock_owner;
  // a lock blocks the non-owner entirely until the owner releases or goes idle
  always_comb begin
    elig0 = m0_req & ~(lock_act & lock_owner);
    elig1 = m1_req & ~(lock_act & ~lock_owner);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_act   <= 1'b0;
      lock_owner <= 1'b0;
    end else if (mem_en & (win ? m1_lock : m0_lock)) begin
      lock_act   <= 1'b1;
      lock_owner <= win;
    end else if (lock_act & (mem_en | ~(lock_owner ? m1_req : m0_req))) begin
      lock_act   <= 1'b0;
    end
  end
`else
  logic unused_lock;
  always_comb begin
    elig0       = m0_req;
    elig1       = m1_req;
    unused_lock = m0_lock ^ m1_lock;
  end
`endif
  always_comb begin
    m0_gnt    = ~reset & elig0 & (~elig1 | last);
    m1_gnt    = ~reset & elig1 & (~elig0 | ~last);
    win       = m1_gnt;
    mem_en    = m0_gnt | m1_gnt;
    mem_we    = mem_en & (win ? m1_we : m0_we);
    mem_addr  = mem_en ? (win ? m1_addr : m0_addr) : '0;
    mem_wdata = mem_en ? (win ? m1_wdata : m0_wdata) : '0;
    // reset gating drops a read that was in flight when reset arrived
    m0_rvalid = ~reset & rd_pend & ~rd_owner;
    m1_rvalid = ~reset & rd_pend & rd_owner;
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = m1_rvalid ? mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last     <= 1'b1;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= mem_en & ~mem_we;
      if (mem_en) begin
        last     <= win;
        rd_owner <= win;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus lock/no-lock contention sequence for mem_arbiter.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // synchronous single-port memory seen by the arbiter
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  typedef struct {
    logic        rst, r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        g0, g1, v0, v1;
    logic [31:0] rd0, rd1;
    logic        en, we;
    logic [31:0] ma, md;
  } vec_t;

  function automatic vec_t mk(logic rst, logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
                              logic g0, logic g1, logic v0, logic v1,
                              logic [31:0] rd0, logic [31:0] rd1,
                              logic en, logic we, logic [31:0] ma, logic [31:0] md);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd0 = rd0; v.rd1 = rd1;
    v.en = en; v.we = we; v.ma = ma; v.md = md;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic r0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic l0, input logic r1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1, input logic l1);
    reset = rst; m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_lock = l0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_lock = l1;
  endtask

  vec_t vt [21];
  logic exp_g1 [5];
  logic lk;
  int k;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[0]  = mk(1, 1,0,32'h40,0, 1,0,32'h10,0, 0,0,0,0, 0,0, 0,0,0,0);
    vt[1]  = vt[0];
    vt[2]  = vt[0];
    vt[3]  = mk(0, 1,0,32'h20,0, 1,0,32'h10,0, 1,0,0,0, 0,0, 1,0,32'h20,0);
    vt[4]  = mk(0, 0,0,0,0, 1,0,32'h10,0, 0,1,1,0, 32'h10000020,0, 1,0,32'h10,0);
    vt[5]  = mk(0, 1,1,32'h40,32'hDEADBEEF, 0,0,0,0, 1,0,0,1, 0,32'h10000010, 1,1,32'h40,32'hDEADBEEF);
    vt[6]  = mk(0, 1,0,32'h40,0, 0,0,0,0, 1,0,0,0, 0,0, 1,0,32'h40,0);
    vt[7]  = mk(0, 0,0,0,0, 0,0,0,0, 0,0,1,0, 32'hDEADBEEF,0, 0,0,0,0);
    vt[8]  = mk(0, 0,0,0,0, 1,0,32'h10,0, 0,1,0,0, 0,0, 1,0,32'h10,0);
    vt[9]  = mk(0, 1,0,32'h1,0, 1,0,32'h2,0, 1,0,0,1, 0,32'h10000010, 1,0,32'h1,0);
    vt[10] = mk(0, 1,0,32'h3,0, 1,0,32'h2,0, 0,1,1,0, 32'h10000001,0, 1,0,32'h2,0);
    vt[11] = mk(0, 1,0,32'h3,0, 1,0,32'h4,0, 1,0,0,1, 0,32'h10000002, 1,0,32'h3,0);
    vt[12] = mk(0, 1,0,32'h5,0, 1,0,32'h4,0, 0,1,1,0, 32'h10000003,0, 1,0,32'h4,0);
    vt[13] = mk(0, 1,0,32'h5,0, 1,0,32'h6,0, 1,0,0,1, 0,32'h10000004, 1,0,32'h5,0);
    vt[14] = mk(0, 1,0,32'h7,0, 1,0,32'h6,0, 0,1,1,0, 32'h10000005,0, 1,0,32'h6,0);
    vt[15] = mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,1, 0,32'h10000006, 0,0,0,0);
    vt[16] = mk(0, 1,0,32'h8,0, 0,0,0,0, 1,0,0,0, 0,0, 1,0,32'h8,0);
    vt[17] = mk(1, 1,0,32'h9,0, 1,0,32'hA,0, 0,0,0,0, 0,0, 0,0,0,0);
    vt[18] = mk(0, 1,0,32'h9,0, 1,0,32'hA,0, 1,0,0,0, 0,0, 1,0,32'h9,0);
    vt[19] = mk(0, 0,0,0,0, 1,0,32'hA,0, 0,1,1,0, 32'h10000009,0, 1,0,32'hA,0);
    vt[20] = mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,1, 0,32'h1000000A, 0,0,0,0);
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      drive(vt[i].rst, vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0, 1'b0,
            vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1, 1'b0);
      @(negedge clk);
      check("m0_gnt", i, {31'b0, m0_gnt}, {31'b0, vt[i].g0});
      check("m1_gnt", i, {31'b0, m1_gnt}, {31'b0, vt[i].g1});
      check("m0_rvalid", i, {31'b0, m0_rvalid}, {31'b0, vt[i].v0});
      check("m1_rvalid", i, {31'b0, m1_rvalid}, {31'b0, vt[i].v1});
      check("m0_rdata", i, m0_rdata, vt[i].rd0);
      check("m1_rdata", i, m1_rdata, vt[i].rd1);
      check("mem_en", i, {31'b0, mem_en}, {31'b0, vt[i].en});
      check("mem_we", i, {31'b0, mem_we}, {31'b0, vt[i].we});
      check("mem_addr", i, mem_addr, vt[i].ma);
      check("mem_wdata", i, mem_wdata, vt[i].md);
    end
    // m0 wins alone so that m1 takes the first contended cycle below
    @(posedge clk); #1;
    drive(0, 1, 1, 32'h30, 32'h55, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("lock_pre_gnt", 0, {31'b0, m0_gnt}, 32'd1);
`ifdef MEM_ARB_LOCK_EN
    exp_g1 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    exp_g1 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    k = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      lk = (k < 3);
      drive(0, 1, 1, 32'h31, 32'h66, 0, k < 4, 1, 32'h50 + k, 32'hA0 + k, lk);
      @(negedge clk);
      check("lock_m1_gnt", c, {31'b0, m1_gnt}, {31'b0, exp_g1[c]});
      check("lock_m0_gnt", c, {31'b0, m0_gnt}, {31'b0, ~exp_g1[c]});
      if (exp_g1[c]) k++;
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
